rgb_mem_arbiter: RTL

RGB_MEM_ARBITER -- requirements
Module: rgb_mem_arbiter

---
 rtl/rgb_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rgb_mem_arbiter.sv
// rgb_mem_arbiter: shares one RGB memory port between CPU loads/stores and three-bank video pixel reads.
module rgb_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_rgb,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_r,
  output logic [7:0]  vid_g,
  output logic [7:0]  vid_b,
  output logic        vid_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_WAIT, VID_R, VID_G, VID_B, VID_DONE} state_t;
  state_t      state_q;
  logic [1:0]  starv_q;
  logic        we_q;
  logic [1:0]  rgb_q;
  logic [15:0] addr_q;
  logic [7:0]  rdata_q;
  logic [7:0]  vr_q;
  logic [7:0]  vg_q;
  logic [7:0]  vb_q;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [1:0]  mem_sel_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        grant_vid;
  logic        bank_ok;
  logic        cpu_ld;
  // video wins ties unless the CPU has already lost three grants in a row
  assign grant_vid = vid_req && !(cpu_req && starv_q == 2'd3);
  assign bank_ok   = cpu_rgb != 2'd0;
  assign cpu_done  = state_q == CPU_WAIT;
  assign cpu_ld    = cpu_done && (!we_q || rgb_q == 2'd0);
  assign cpu_rdata = cpu_ld ? (rgb_q == 2'd0 ? 8'h00 : mem_rdata) : rdata_q;
  assign cpu_stall = cpu_req && !cpu_done;
  assign vid_ready = state_q == VID_DONE;
  assign vid_r     = vr_q;
  assign vid_g     = vg_q;
  assign vid_b     = vid_ready ? mem_rdata : vb_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starv_q     <= '0;
      we_q        <= 1'b0;
      rgb_q       <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      vr_q        <= '0;
      vg_q        <= '0;
      vb_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: if (grant_vid) begin
          state_q    <= VID_R;
          addr_q     <= vid_addr;
          starv_q    <= (cpu_req && starv_q != 2'd3) ? starv_q + 2'd1 : starv_q;
          mem_en_q   <= 1'b1;
          mem_sel_q  <= 2'd1;
          mem_addr_q <= vid_addr;
        end else if (cpu_req) begin
          state_q     <= bank_ok ? CPU_ACC : CPU_WAIT;
          we_q        <= cpu_we;
          rgb_q       <= cpu_rgb;
          addr_q      <= cpu_addr;
          starv_q     <= '0;
          mem_en_q    <= bank_ok;
          mem_we_q    <= bank_ok && cpu_we;
          mem_sel_q   <= cpu_rgb;
          mem_addr_q  <= bank_ok ? cpu_addr : 16'h0000;
          mem_wdata_q <= bank_ok ? cpu_wdata : 8'h00;
        end
        CPU_ACC: state_q <= CPU_WAIT;
        CPU_WAIT: begin
          state_q <= IDLE;
          rdata_q <= cpu_rdata;
        end
        VID_R: begin
          state_q    <= VID_G;
          mem_en_q   <= 1'b1;
          mem_sel_q  <= 2'd2;
          mem_addr_q <= addr_q;
        end
        VID_G: begin
          state_q    <= VID_B;
          vr_q       <= mem_rdata;
          mem_en_q   <= 1'b1;
          mem_sel_q  <= 2'd3;
          mem_addr_q <= addr_q;
        end
        VID_B: begin
          state_q <= VID_DONE;
          vg_q    <= mem_rdata;
        end
        VID_DONE: begin
          state_q <= IDLE;
          vb_q    <= mem_rdata;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
